// File: rtl/ofdm_symbol_buffer.sv
// Ping-pong symbol buffer between CP removal and the FFT: two banks of sync RAM, valid/ready output.
// Define OFDM_SYMBUF_BITREV_EN to read each symbol out in bit-reversed address order.
module ofdm_symbol_buffer #(
  parameter int DATA_SIZE    = 16,
  parameter int SYMBOLS_SIZE = 256
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  input  logic                 i_cp_removed,
  output logic                 out_valid,
  input  logic                 i_ready,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic                 o_sof,
  output logic                 o_eof,
  output logic                 o_overflow
);

  localparam int ADDR_W = $clog2(SYMBOLS_SIZE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SYMBOLS_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t state, state_next;

  logic [2*DATA_SIZE-1:0] mem [0:2*SYMBOLS_SIZE-1];

  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_bank;
  logic              drop;
  logic [1:0]        full;
  logic [ADDR_W-1:0] rd_cnt;
  logic              rd_bank;
  logic              rd_other;

  logic              wr_take, wr_drop_start, wr_en, wr_last;
  logic [1:0]        full_set, full_clr;
  logic              rd_en, rd_accept, rd_last;
  logic [ADDR_W-1:0] rd_addr_cnt, rd_addr;

  logic signed [DATA_SIZE-1:0] rd_i_p1, rd_q_p1;
  logic                        vld_p1;

`ifdef OFDM_SYMBUF_BITREV_EN
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int b = 0; b < ADDR_W; b++) r[b] = a[ADDR_W-1-b];
    return r;
  endfunction
  assign rd_addr = bitrev(rd_addr_cnt);
`else
  assign rd_addr = rd_addr_cnt;
`endif

  // A bank still held by the reader at the first sample drops the whole symbol.
  assign wr_take       = i_valid && i_cp_removed && !drop;
  assign wr_drop_start = wr_take && (wr_cnt == '0) && full[wr_bank];
  assign wr_en         = wr_take && !wr_drop_start;
  assign wr_last       = wr_en && (wr_cnt == LAST);

  assign full_set = {wr_last && wr_bank, wr_last && !wr_bank};
  assign full_clr = {rd_last && rd_bank, rd_last && !rd_bank};
  assign rd_other = ~rd_bank;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[{wr_bank, wr_cnt}] <= {in_data_i, in_data_q};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      drop       <= 1'b0;
      full       <= 2'b00;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= wr_drop_start;
      if (!i_cp_removed) begin
        wr_cnt <= '0;
        drop   <= 1'b0;
      end else if (wr_drop_start) begin
        drop <= 1'b1;
      end else if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      full <= (full | full_set) & ~full_clr;
      if (rd_accept) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // FETCH reads address 0; each accepted beat in STREAM prefetches the next address.
  always_comb begin
    state_next  = state;
    rd_en       = 1'b0;
    rd_accept   = 1'b0;
    rd_last     = 1'b0;
    rd_addr_cnt = rd_cnt;
    case (state)
      IDLE: begin
        if (full[rd_bank]) state_next = FETCH;
      end
      FETCH: begin
        rd_en      = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        if (i_ready) begin
          rd_accept = 1'b1;
          if (rd_cnt == LAST) begin
            rd_last    = 1'b1;
            state_next = full[rd_other] ? FETCH : IDLE;
          end else begin
            rd_en       = 1'b1;
            rd_addr_cnt = rd_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read stage: registered RAM output feeds the ports directly
  always_ff @(posedge i_clk) begin
    if (rd_en) {rd_i_p1, rd_q_p1} <= mem[{rd_bank, rd_addr}];
  end

  assign vld_p1     = (state == STREAM);
  assign out_valid  = vld_p1;
  assign out_data_i = vld_p1 ? rd_i_p1 : '0;
  assign out_data_q = vld_p1 ? rd_q_p1 : '0;
  assign o_sof      = vld_p1 && (rd_cnt == '0);
  assign o_eof      = vld_p1 && (rd_cnt == LAST);

endmodule
